// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Runs a masked subset of network layers on the core in ascending order:
//   pulses a core reset at run start, waits a programmable gap before every
//   launch, then launches each enabled layer and waits for its completion.
//   Supports loop mode, abort at layer boundaries, a per-layer RUN-cycle
//   counter and an optional per-layer timeout.
//
// Ports
//   i_core_clk     core clock, all logic on rising edge
//   i_reset        asynchronous active-high reset
//   i_start        run request, sampled only in IDLE
//   i_layer_mask   bit i enables layer i, latched on start
//   i_loop_mode    repeat the masked sequence until aborted, latched on start
//   i_abort        level, ends the run at the next layer boundary
//   i_layer_done   one-cycle completion pulse from the core, used only in RUN
//   o_core_rst     reset to the core datapath
//   o_layer_start  one-cycle launch pulse
//   o_layer_id     layer being launched / run
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse when a run ends
//   o_aborted      sticky: run ended by abort
//   o_timeout      sticky: a layer exceeded TIMEOUT_CYCLES
//   o_last_cycles  RUN-cycle count of the most recently completed layer
module layer_sequencer #(
    parameter int NUM_LAYERS     = 8,
    parameter int RST_CYCLES     = 1,
    parameter int GAP_CYCLES     = 1,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int ID_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  i_core_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [NUM_LAYERS-1:0] i_layer_mask,
    input  logic                  i_loop_mode,
    input  logic                  i_abort,
    input  logic                  i_layer_done,
    output logic                  o_core_rst,
    output logic                  o_layer_start,
    output logic [ID_W-1:0]       o_layer_id,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted,
    output logic                  o_timeout,
    output logic [CNT_W-1:0]      o_last_cycles
);

    // Terminal values of the shared wait counter; a zero-length gap still
    // spends its single GAP cycle.
    localparam int RST_LAST = (RST_CYCLES > 1) ? RST_CYCLES - 1 : 0;
    localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_GAP, S_LAUNCH, S_RUN, S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [NUM_LAYERS-1:0] r_mask;
    logic                  r_loop;
    logic [ID_W-1:0]       r_idx;
    logic [31:0]           r_wait;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_last;
    logic                  r_aborted;
    logic                  r_timeout;

    logic [ID_W-1:0]       w_start_idx;
    logic [ID_W-1:0]       w_wrap_idx;
    logic [ID_W-1:0]       w_nxt_idx;
    logic                  w_nxt_found;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_to_hit;
    logic                  w_rst_end;
    logic                  w_gap_end;

    // Priority pickers: scanning downward lets the lowest qualifying bit win.
    always_comb begin
        w_start_idx = '0;
        w_wrap_idx  = '0;
        w_nxt_idx   = '0;
        w_nxt_found = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (i_layer_mask[i]) w_start_idx = ID_W'(i);
            if (r_mask[i])       w_wrap_idx  = ID_W'(i);
            if (r_mask[i] && (i > int'(r_idx))) begin
                w_nxt_found = 1'b1;
                w_nxt_idx   = ID_W'(i);
            end
        end
    end

    // Count including the current RUN cycle, saturating at all-ones.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_to_hit  = (TIMEOUT_CYCLES != 0) && (w_cnt_inc >= CNT_W'(TIMEOUT_CYCLES));
    assign w_rst_end = (r_wait == 32'(RST_LAST));
    assign w_gap_end = (r_wait == 32'(GAP_LAST));

    always_ff @(posedge i_core_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        o_busy        = (r_state != S_IDLE);
        o_done        = 1'b0;
        o_layer_start = 1'b0;
        o_core_rst    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = (|i_layer_mask) ? S_RST : S_FIN;
            end
            S_RST: begin
                o_core_rst = 1'b1;
                if (i_abort)        w_next = S_FIN;
                else if (w_rst_end) w_next = S_GAP;
            end
            S_GAP: begin
                if (i_abort)        w_next = S_FIN;
                else if (w_gap_end) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                o_layer_start = 1'b1;
                w_next        = S_RUN;
            end
            S_RUN: begin
                // layer_done takes precedence over a timeout in the same cycle
                if (i_layer_done) begin
                    if (i_abort)                     w_next = S_FIN;
                    else if (w_nxt_found || r_loop)  w_next = S_GAP;
                    else                             w_next = S_FIN;
                end else if (w_to_hit) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                o_done = 1'b1;
                // r_timeout is cleared at every start, so here it can only
                // mean this run just timed out: give the core a reset pulse.
                o_core_rst = r_timeout;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_core_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mask    <= '0;
            r_loop    <= 1'b0;
            r_idx     <= '0;
            r_wait    <= '0;
            r_cnt     <= '0;
            r_last    <= '0;
            r_aborted <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mask    <= i_layer_mask;
                        r_loop    <= i_loop_mode;
                        r_idx     <= w_start_idx;
                        r_wait    <= '0;
                        r_aborted <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_RST: begin
                    if (i_abort)        r_aborted <= 1'b1;
                    else if (w_rst_end) r_wait    <= '0;
                    else                r_wait    <= r_wait + 32'd1;
                end
                S_GAP: begin
                    if (i_abort) r_aborted <= 1'b1;
                    else         r_wait    <= r_wait + 32'd1;
                end
                S_LAUNCH: r_cnt <= '0;
                S_RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (i_layer_done) begin
                        r_last <= w_cnt_inc;
                        r_wait <= '0;
                        if (i_abort)          r_aborted <= 1'b1;
                        else if (w_nxt_found) r_idx     <= w_nxt_idx;
                        else if (r_loop)      r_idx     <= w_wrap_idx;
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_layer_id    = r_idx;
    assign o_aborted     = r_aborted;
    assign o_timeout     = r_timeout;
    assign o_last_cycles = r_last;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (RST_CYCLES=1, GAP_CYCLES=1,
// TIMEOUT_CYCLES=20). A responder answers each layer_start with a
// layer_done rsp_delay cycles later (0 = never answers) and logs launches,
// core resets and completions with cycle stamps.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  layer_mask = 8'h00;
    logic        loop_mode = 1'b0;
    logic        abort = 1'b0;
    logic        layer_done = 1'b0;
    logic        o_core_rst, o_layer_start, o_busy, o_done, o_aborted, o_timeout;
    logic [2:0]  o_layer_id;
    logic [31:0] o_last_cycles;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_delay = 0;
    int rsp_cnt = 0;
    int mon_rst = 0;
    int mon_ids[$];
    int mon_st[$];
    int mon_ld[$];

    layer_sequencer #(
        .NUM_LAYERS(8), .RST_CYCLES(1), .GAP_CYCLES(1), .CNT_W(32), .TIMEOUT_CYCLES(20)
    ) dut (
        .i_core_clk(clk), .i_reset(reset), .i_start(start), .i_layer_mask(layer_mask),
        .i_loop_mode(loop_mode), .i_abort(abort), .i_layer_done(layer_done),
        .o_core_rst(o_core_rst), .o_layer_start(o_layer_start), .o_layer_id(o_layer_id),
        .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_timeout(o_timeout),
        .o_last_cycles(o_last_cycles)
    );

    always #5 clk = ~clk;

    // Responder / logger: runs 1 time unit after each edge, stamps cycle cyc.
    always begin
        @(posedge clk); #1;
        cyc++;
        if (reset) begin
            rsp_cnt    = 0;
            layer_done = 1'b0;
        end else begin
            layer_done = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    layer_done = 1'b1;
                    mon_ld.push_back(cyc);
                end
            end
            if (o_layer_start) begin
                mon_ids.push_back(int'(o_layer_id));
                mon_st.push_back(cyc);
                if (rsp_delay > 0) rsp_cnt = rsp_delay;
            end
            if (o_core_rst) mon_rst++;
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic clr_logs();
        mon_ids.delete(); mon_st.delete(); mon_ld.delete(); mon_rst = 0;
    endtask

    task automatic do_start(input logic [7:0] m, input logic lp, output int s);
        layer_mask = m; loop_mode = lp; start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string nm, output int d);
        int n = 0;
        while (o_done !== 1'b1 && n < bound) begin tick(); n++; end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_done: done=%b after %0d cycles, required 1", nm, o_done, n);
        end
        d = cyc;
    endtask

    task automatic wait_ids(input int k, input int bound, input string nm);
        int n = 0;
        while (mon_ids.size() < k && n < bound) begin tick(); n++; end
        checks++;
        if (mon_ids.size() < k) begin
            errors++;
            $display("FAIL %s_wait_launch: launches=%0d, required %0d", nm, mon_ids.size(), k);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({o_core_rst, o_layer_start, o_layer_id, o_busy, o_done, o_aborted, o_timeout} !== 9'd0
            || o_last_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: rst=%b ls=%b id=%0d busy=%b done=%b ab=%b to=%b last=%0d, required all 0",
                     o_core_rst, o_layer_start, o_layer_id, o_busy, o_done, o_aborted, o_timeout, o_last_cycles);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_core_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b core_rst=%b, required 0 0", o_busy, o_core_rst);
        end
    endtask

    task automatic test_single();
        int s, d;
        clr_logs(); rsp_delay = 10;
        do_start(8'h10, 1'b0, s);
        wait_done(60, "single", d);
        checks++;
        if (d - s !== 14) begin errors++; $display("FAIL single_latency: got %0d, required 14", d - s); end
        checks++;
        if (mon_rst !== 1) begin errors++; $display("FAIL single_core_rst: got %0d cycles, required 1", mon_rst); end
        checks++;
        if (mon_ids.size() !== 1 || mon_ids[0] !== 4) begin
            errors++; $display("FAIL single_ids: count %0d first %0d, required 1 launch of id 4",
                               mon_ids.size(), (mon_ids.size() > 0) ? mon_ids[0] : -1);
        end
        checks++;
        if (o_last_cycles !== 32'd10) begin errors++; $display("FAIL single_last_cycles: got %0d, required 10", o_last_cycles); end
        checks++;
        if (o_busy !== 1'b1 || o_aborted !== 1'b0) begin
            errors++; $display("FAIL single_fin_flags: busy=%b aborted=%b, required 1 0", o_busy, o_aborted);
        end
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL single_after: busy=%b done=%b, required 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_mask_order();
        int s, d;
        int exp_ids[4] = '{0, 2, 5, 7};
        clr_logs(); rsp_delay = 3;
        do_start(8'hA5, 1'b0, s);
        wait_done(100, "order", d);
        checks++;
        if (d - s !== 22) begin errors++; $display("FAIL order_latency: got %0d, required 22", d - s); end
        checks++;
        if (mon_rst !== 1) begin errors++; $display("FAIL order_core_rst: got %0d cycles, required 1", mon_rst); end
        checks++;
        if (mon_ids.size() !== 4) begin
            errors++; $display("FAIL order_count: got %0d launches, required 4", mon_ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (mon_ids[k] !== exp_ids[k]) begin
                    errors++; $display("FAIL order_id%0d: got %0d, required %0d", k, mon_ids[k], exp_ids[k]);
                end
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (mon_st[k] - mon_ld[k-1] !== 2) begin
                    errors++; $display("FAIL order_gap%0d: done-to-start %0d cycles, required 2", k, mon_st[k] - mon_ld[k-1]);
                end
            end
        end
        checks++;
        if (o_last_cycles !== 32'd3) begin errors++; $display("FAIL order_last_cycles: got %0d, required 3", o_last_cycles); end
        tick();
    endtask

    task automatic test_loop_abort();
        int s, d;
        clr_logs(); rsp_delay = 5;
        do_start(8'h03, 1'b1, s);
        wait_ids(3, 60, "loop");
        tick();
        abort = 1'b1;
        wait_done(40, "loop", d);
        checks++;
        if (d - s !== 23) begin errors++; $display("FAIL loop_latency: got %0d, required 23", d - s); end
        checks++;
        if (o_aborted !== 1'b1) begin errors++; $display("FAIL loop_aborted: got %b, required 1", o_aborted); end
        checks++;
        if (mon_ids.size() !== 3 || mon_ids[0] !== 0 || mon_ids[1] !== 1 || mon_ids[2] !== 0) begin
            errors++; $display("FAIL loop_ids: count %0d, required ids 0,1,0", mon_ids.size());
        end
        checks++;
        if (mon_rst !== 1 || o_last_cycles !== 32'd5) begin
            errors++; $display("FAIL loop_rst_last: core_rst %0d last %0d, required 1 5", mon_rst, o_last_cycles);
        end
        abort = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (mon_ids.size() !== 3 || o_busy !== 1'b0 || o_aborted !== 1'b1) begin
            errors++; $display("FAIL loop_quiet: launches %0d busy %b aborted %b, required 3 0 1",
                               mon_ids.size(), o_busy, o_aborted);
        end
    endtask

    task automatic test_timeout();
        int s, d;
        clr_logs(); rsp_delay = 0;
        do_start(8'h04, 1'b0, s);
        wait_done(80, "timeout", d);
        checks++;
        if (mon_st.size() !== 1 || d - mon_st[0] !== 21) begin
            errors++; $display("FAIL timeout_latency: launches %0d, launch-to-done %0d, required 1 21",
                               mon_st.size(), (mon_st.size() > 0) ? d - mon_st[0] : -1);
        end
        checks++;
        if (o_timeout !== 1'b1 || o_core_rst !== 1'b1 || o_aborted !== 1'b0) begin
            errors++; $display("FAIL timeout_fin: timeout=%b core_rst=%b aborted=%b, required 1 1 0",
                               o_timeout, o_core_rst, o_aborted);
        end
        checks++;
        if (o_last_cycles !== 32'd5) begin errors++; $display("FAIL timeout_last_kept: got %0d, required 5", o_last_cycles); end
        tick();
        checks++;
        if (o_core_rst !== 1'b0 || o_timeout !== 1'b1 || mon_rst !== 2) begin
            errors++; $display("FAIL timeout_after: core_rst=%b timeout=%b rst_cycles=%0d, required 0 1 2",
                               o_core_rst, o_timeout, mon_rst);
        end
        // layer_done on the very cycle the count reaches the limit wins
        clr_logs(); rsp_delay = 20;
        do_start(8'h04, 1'b0, s);
        checks++;
        if (o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b, required 0", o_timeout); end
        wait_done(80, "edge", d);
        checks++;
        if (o_timeout !== 1'b0 || o_last_cycles !== 32'd20 || mon_rst !== 1) begin
            errors++; $display("FAIL timeout_edge: timeout=%b last=%0d rst_cycles=%0d, required 0 20 1",
                               o_timeout, o_last_cycles, mon_rst);
        end
        tick();
    endtask

    task automatic test_zero_and_busy_start();
        int s, d;
        clr_logs(); rsp_delay = 4;
        do_start(8'h00, 1'b0, s);
        checks++;
        if (o_done !== 1'b1 || o_core_rst !== 1'b0 || o_layer_start !== 1'b0) begin
            errors++; $display("FAIL zero_done: done=%b core_rst=%b layer_start=%b, required 1 0 0",
                               o_done, o_core_rst, o_layer_start);
        end
        tick();
        checks++;
        if (o_busy !== 1'b0 || mon_rst !== 0 || mon_ids.size() !== 0) begin
            errors++; $display("FAIL zero_after: busy=%b rst_cycles=%0d launches=%0d, required 0 0 0",
                               o_busy, mon_rst, mon_ids.size());
        end
        clr_logs();
        do_start(8'h12, 1'b0, s);
        tick(); tick(); tick();
        layer_mask = 8'hFF; loop_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; layer_mask = 8'h00; loop_mode = 1'b0;
        wait_done(60, "busy_start", d);
        checks++;
        if (d - s !== 14) begin errors++; $display("FAIL busy_start_latency: got %0d, required 14", d - s); end
        checks++;
        if (mon_ids.size() !== 2 || mon_ids[0] !== 1 || mon_ids[1] !== 4 || mon_rst !== 1) begin
            errors++; $display("FAIL busy_start_seq: launches %0d rst_cycles %0d, required ids 1,4 and 1",
                               mon_ids.size(), mon_rst);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int s, d;
        clr_logs(); rsp_delay = 6;
        do_start(8'h07, 1'b0, s);
        wait_ids(3, 60, "midrst");
        tick(); tick();
        checks++;
        if (o_busy !== 1'b1 || o_layer_id !== 3'd2 || o_last_cycles !== 32'd6) begin
            errors++; $display("FAIL midrst_pre: busy=%b id=%0d last=%0d, required 1 2 6",
                               o_busy, o_layer_id, o_last_cycles);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({o_core_rst, o_layer_start, o_layer_id, o_busy, o_done, o_aborted, o_timeout} !== 9'd0
            || o_last_cycles !== 32'd0) begin
            errors++; $display("FAIL midrst_outputs: rst=%b ls=%b id=%0d busy=%b done=%b last=%0d, required all 0",
                               o_core_rst, o_layer_start, o_layer_id, o_busy, o_done, o_last_cycles);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        clr_logs(); rsp_delay = 7;
        do_start(8'h08, 1'b0, s);
        wait_done(60, "rerun", d);
        checks++;
        if (d - s !== 11 || mon_rst !== 1 || mon_ids.size() !== 1 || mon_ids[0] !== 3 || o_last_cycles !== 32'd7) begin
            errors++; $display("FAIL rerun: latency %0d rst_cycles %0d launches %0d last %0d, required 11 1 1 7",
                               d - s, mon_rst, mon_ids.size(), o_last_cycles);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_mask_order();
        test_loop_abort();
        test_timeout();
        test_zero_and_busy_start();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
